ctrl_pipe_chain: RTL
====================

// Module: ctrl_pipe_chain
// PURPOSE
//  Parametrised control-signal pipeline carrying decoded control words from decode to writeback.
//  Generalises the fixed E/M/W control registers to NSTAGES stages of width CW.
//  Each stage has its own stall and flush, a valid bit, and automatic bubble insertion.
//  Per-stage exception kill clears selected bits, e.g. regwrite on overflow.
//  Detects illegal stall patterns and raises a sticky error.
// PARAMETERS
//  NSTAGES   3          number of pipeline stages after decode (0=E,1=M,2=W); range 1..8
//  CW        12         control word width in bits
//  KILL_MASK 12'h008    bits cleared when a word leaves a killed stage (default: regwrite)
//  FLUSH_VAL {CW{1'b0}} control word loaded on flush or bubble
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          reset; asynchronous, active-high
//  ctrl_d     in   CW         decoded control word entering stage 0
//  valid_d    in   1          ctrl_d holds a real instruction
//  stall      in   NSTAGES    stall[k]=1: stage k holds its contents
//  flush      in   NSTAGES    flush[k]=1: stage k loads FLUSH_VAL, valid=0
//  kill       in   NSTAGES    kill[k]=1: word leaving stage k has KILL_MASK bits cleared
//  ctrl_q     out  NSTAGES*CW stage k word at [k*CW +: CW]
//  valid_q    out  NSTAGES    per-stage valid
//  stall_err  out  1          sticky: illegal stall pattern seen
// BEHAVIOUR
//  - Reset (async): every stage ctrl=FLUSH_VAL, valid_q=0, stall_err=0.
//  - Latency: a word in ctrl_d at edge n appears in stage 0 after edge n.
//    With no stalls it reaches stage k after edge n+k.
//  - Per stage k, per rising edge, priority order:
//      flush[k] > stall[k] > bubble > load.
//      flush[k]: load FLUSH_VAL, valid=0. Flush overrides stall.
//      stall[k] (no flush): hold word and valid.
//      bubble: if k>0 and stall[k-1]=1 while stall[k]=0, load FLUSH_VAL, valid=0.
//      load: stage 0 takes ctrl_d/valid_d; stage k takes stage k-1.
//  - Kill: the word moving from stage k into stage k+1 is (q[k] & ~KILL_MASK).
//      The valid bit is unchanged by kill.
//      kill[k] has no effect while stage k+1 is stalled, flushed or bubbling.
//      kill[NSTAGES-1] is ignored; there is no successor stage.
//      Kill never alters a word that stays in place (held).
//  - Stall legality: stall[k]=1 requires stall[j]=1 for all j<k.
//      A violation on any cycle sets stall_err at the next edge; cleared only by rst.
//      The data path still follows the priority rules above, so stage k-1's word may be lost.
//  - Simultaneous flush[k] and kill[k-1]: flush wins; stage k gets FLUSH_VAL.
//  - Reset mid-operation: all state is cleared immediately (async); no partial words survive.
//  - No combinational path from stall/flush/kill to ctrl_q/valid_q.
//  - ctrl_d is registered unmodified; no decode takes place in this block.
// STRUCTURE
//  - Shared package ctrl_pipe_pkg:
//      field index constants CTL_MEMTOREG, CTL_MEMWRITE, CTL_ALUSRC, CTL_REGDST,
//        CTL_REGWRITE, CTL_MEMEN, CTL_ALUCTL_LSB/MSB, CTL_CP0WE;
//      default CW and KILL_MASK;
//      stage index constants ST_E=0, ST_M=1, ST_W=2.
//  - Sub-module ctrl_stage_reg: one stage. Async-reset register of CW+1 bits with
//      inputs en, clr, d, and reset/clear value FLUSH_VAL.
//      Instantiated NSTAGES times via generate.
//  - Top level holds the next-word mux (load/bubble/kill) and the stall-legality checker.
// TESTING
//  - Free flow: valid_d=1, ctrl_d=12'hA5C, no stalls.
//      -> stage0=A5C at edge 1, stage1 at edge 2, stage2 at edge 3; valid_q=3'b111 after 3 edges.
//  - Stall+bubble: stall=3'b001 for 2 cycles with stage0=12'h123.
//      -> stage0 holds 123; stage1 gets 000/valid 0 for 2 cycles; 123 enters stage1 once released.
//  - Kill: stage0=12'hFFF, kill=3'b001 for one edge.
//      -> stage1=FF7, valid 1. kill[2]=1 alone -> no word changes.
//  - Flush vs stall: stall=3'b011, flush=3'b010.
//      -> stage1=000/valid 0, stage0 held, stall_err stays 0.
//  - Illegal stall: stall=3'b010 for one cycle.
//      -> stall_err=1 at next edge and stays 1 until rst.
//  - Async reset: assert rst mid-stream, not aligned to clk.
//      -> ctrl_q=0, valid_q=0, stall_err=0 immediately, before any clock edge.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the decode-to-writeback control-word pipeline:
// control word field positions, default widths/masks and stage indices.
package ctrl_pipe_pkg;

   // Control word field positions
   localparam int CTL_MEMTOREG   = 0;
   localparam int CTL_MEMWRITE   = 1;
   localparam int CTL_ALUSRC     = 2;
   localparam int CTL_REGWRITE   = 3;
   localparam int CTL_REGDST     = 4;
   localparam int CTL_MEMEN      = 5;
   localparam int CTL_ALUCTL_LSB = 6;
   localparam int CTL_ALUCTL_MSB = 9;
   localparam int CTL_CP0WE      = 10;

   // Default control word width and the bits dropped from a killed word
   localparam int                 CW_DEF        = 12;
   localparam logic [CW_DEF-1:0]  KILL_MASK_DEF = 12'h008;  // regwrite only

   // Stage indices after decode
   localparam int ST_E = 0;
   localparam int ST_M = 1;
   localparam int ST_W = 2;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: {valid, ctrl} register with enable and a clear that
// loads the flush value. Clear wins over enable.
module ctrl_stage_reg
   import ctrl_pipe_pkg::*;
#(
   parameter int            CW        = CW_DEF,
   parameter logic [CW-1:0] FLUSH_VAL = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   input  logic [CW:0] d,
   output logic [CW:0] q
);

   // Stage register: reset/clear to an invalid flush word, otherwise load when enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= {1'b0, FLUSH_VAL};
      end else if (clr) begin
         q <= {1'b0, FLUSH_VAL};
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline of NSTAGES stages carrying decoded control from
// decode to writeback, with per-stage stall/flush, bubble insertion on a
// stall boundary, per-stage kill masking and a sticky stall-legality flag.
module ctrl_pipe_chain
   import ctrl_pipe_pkg::*;
#(
   parameter int            NSTAGES   = 3,
   parameter int            CW        = CW_DEF,
   parameter logic [CW-1:0] KILL_MASK = KILL_MASK_DEF,
   parameter logic [CW-1:0] FLUSH_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CW-1:0]         ctrl_d,
   input  logic                  valid_d,
   input  logic [NSTAGES-1:0]    stall,
   input  logic [NSTAGES-1:0]    flush,
   input  logic [NSTAGES-1:0]    kill,
   output logic [NSTAGES*CW-1:0] ctrl_q,
   output logic [NSTAGES-1:0]    valid_q,
   output logic                  stall_err
);

   logic [CW:0] stage_q [NSTAGES];
   logic        stall_bad;

   // The last stage has no successor, so its kill bit goes nowhere
   logic unused_kill_last;
   assign unused_kill_last = kill[NSTAGES-1];

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      logic [CW-1:0] src_word;
      logic          src_valid;
      logic          bubble;

      if (k == 0) begin : g_head
         assign src_word  = ctrl_d;
         assign src_valid = valid_d;
         assign bubble    = 1'b0;
      end else begin : g_body
         // Kill only shapes the word in flight; a held word is never touched
         assign src_word  = kill[k-1] ? (stage_q[k-1][CW-1:0] & ~KILL_MASK)
                                      : stage_q[k-1][CW-1:0];
         assign src_valid = stage_q[k-1][CW];
         assign bubble    = stall[k-1] & ~stall[k];
      end

      ctrl_stage_reg #(
         .CW        (CW),
         .FLUSH_VAL (FLUSH_VAL)
      ) u_stage (
         .clk (clk),
         .rst (rst),
         .en  (~stall[k]),
         .clr (flush[k] | bubble),
         .d   ({src_valid, src_word}),
         .q   (stage_q[k])
      );

      assign ctrl_q[k*CW +: CW] = stage_q[k][CW-1:0];
      assign valid_q[k]         = stage_q[k][CW];
   end

   // A stalled stage requires every earlier stage to be stalled as well
   always_comb begin
      stall_bad = 1'b0;
      for (int k = 1; k < NSTAGES; k++) begin
         if (stall[k] && !stall[k-1]) begin
            stall_bad = 1'b1;
         end
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_err <= 1'b0;
      end else if (stall_bad) begin
         stall_err <= 1'b1;
      end
   end

endmodule
